wb_b3_burst_master: RTL and testbench
=====================================

# wb_b3_burst_master

Wishbone B3 burst initiator that turns single-word-per-cycle command and data streams into registered-feedback incrementing bursts of 1 to 2^MAX_BURST_LOG2 words. It sits on a master port of the system Wishbone bus beside the CPU instruction and data masters, and targets B3-registered-feedback slaves such as the main RAM. It serves bus traffic generation, DMA front-ends and memory preload in simulation.

## Interface
- AW, 32: address width.
- DW, 32: data width; the address advances by DW/8 per beat.
- MAX_BURST_LOG2, 4: maximum burst of 16 beats; sets the write FIFO depth.
- MAX_RETRY, 15: number of rty responses tolerated per command before abort.

Ports:
- wb_clk_i  in  1  clock; everything is on the rising edge.
- wb_rst_n_i  in  1  reset, asynchronous and active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when this and cmd_valid_i are both high at a rising edge.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_adr_i  in  AW  start byte address, word-aligned.
- cmd_len_i  in  MAX_BURST_LOG2  beats minus 1.
- wdat_i  in  DW  write data stream.
- wdat_valid_i  in  1  write data valid.
- wdat_ready_o  out  1  write data accepted.
- rdat_o  out  DW  read data; no backpressure.
- rdat_valid_o  out  1  one-cycle pulse per read beat.
- done_o  out  1  one-cycle pulse when a command completes.
- err_o  out  1  one-cycle pulse when a command aborts.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_dat_o  out  DW  Wishbone write data.
- wbm_sel_o  out  DW/8  byte selects; constant all-ones.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type.
- wbm_bte_o  out  2  burst type; constant 2'b00 (linear).
- wbm_dat_i  in  DW  read data from slave.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  error.
- wbm_rty_i  in  1  retry.

## Operation
- States: IDLE, WFILL, BURST, RGAP.
- IDLE: cmd_ready_o=1. On accept, the block latches adr, len, we and beats_left=len+1, and clears the retry count. It then goes to WFILL for a write or to BURST for a read.
- WFILL: wdat_ready_o=1 while the FIFO holds fewer than len+1 words. When the count reaches len+1, the block goes to BURST. A write burst never starts until its data is fully buffered.
- BURST: cyc and stb are high continuously; stb is never dropped mid-burst. wbm_dat_o is the FIFO head.
- CTI rule: cti=3'b010 while beats_left>1; cti=3'b111 on the last beat, including single-beat commands.
- Ack sampled while beats_left>1: adr+=DW/8, beats_left−1, pop FIFO (write) or pulse rdat_valid_o with rdat_o=wbm_dat_i (read). These take effect at the same edge, so the next beat follows with no bubble.
- Ack sampled on the last beat: cyc and stb drop, done_o pulses, state goes to IDLE.
- Err sampled: cyc and stb drop, err_o pulses, the FIFO is flushed, state goes to IDLE. Err has priority over simultaneous ack or rty.
- Rty sampled: cyc and stb drop and state goes to RGAP for exactly one cycle, with adr, beats_left and FIFO unchanged and the retry count incremented. The block then re-enters BURST with cti recomputed from the current beats_left.
- Rty when the retry count already equals MAX_RETRY: handled as err.
- Rty has priority over ack.
- Address wraps modulo 2^AW.
- Ack, err and rty are ignored while stb=0.

## Timing
- Reset values: cyc, stb, we, cti, adr, dat, done, err, rdat_valid, wdat_ready and cmd_ready are all 0. The FIFO is empty, state is IDLE, and cmd_ready_o=1 from the first edge after reset release.
- Reset mid-burst: cyc and stb drop asynchronously. The command is lost and no done_o or err_o is issued.
- Read latency: cyc and stb are high in the cycle after command accept.
- Write latency: BURST starts in the cycle after the (len+1)th word is accepted.
- rdat_valid_o is registered, one cycle after the ack edge.
- Throughput: 1 beat per cycle when the slave acks continuously.
- done_o and err_o rise in the cycle after the terminating response.
- cmd_ready_o is 0 from accept until done_o or err_o. It returns to 1 in the same cycle as the done_o or err_o pulse.

## Test plan
- Read, len=3, adr=0x100, slave acks every cycle: cti sequence 010,010,010,111; adr 0x100–0x10C. Four rdat_valid_o pulses with the RAM data. done_o pulses 1 cycle after the 4th ack; cyc is high for exactly 4 cycles.
- Write, len=15, with wdat_valid_i driven only on alternate cycles: no cyc until 16 words are buffered. Then a 16-cycle gap-free burst with data in order; memory readback matches.
- Single write, len=0: cti=111, one beat, done_o pulses.
- Rty on beat 2 of a 4-beat read: one-cycle cyc gap, restart at adr+8 with cti 010,111. A total of 4 rdat_valid_o pulses.
- 16 consecutive rty: err_o pulses, the FIFO is empty afterwards, and cmd_ready_o=1.
- wb_rst_n_i asserted mid-burst: cyc and stb are low before the next edge. No done_o; after release, a new read completes normally.

Source files
------------

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 registered-feedback incrementing burst master (1..2^MAX_BURST_LOG2 beats).
// Write bursts start only once all their data sits in the local FIFO, so stb never drops mid-burst.
module wb_b3_burst_fifo #(
   parameter int DW = 32,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_dat,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [DW-1:0] o_head,
   output logic [LW:0]   o_cnt
);
   logic [DW-1:0] r_mem [2**LW];
   logic [LW-1:0] r_wp;
   logic [LW-1:0] r_rp;
   logic [LW:0]   r_cnt;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp] <= i_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + LW'(1);
         if (i_pop)  r_rp <= r_rp + LW'(1);
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + (LW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (LW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head = r_mem[r_rp];
   assign o_cnt  = r_cnt;
endmodule

module wb_b3_burst_master #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int MAX_BURST_LOG2 = 4,
   parameter int MAX_RETRY      = 15
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_n_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_we_i,
   input  logic [AW-1:0]             cmd_adr_i,
   input  logic [MAX_BURST_LOG2-1:0] cmd_len_i,
   input  logic [DW-1:0]             wdat_i,
   input  logic                      wdat_valid_i,
   output logic                      wdat_ready_o,
   output logic [DW-1:0]             rdat_o,
   output logic                      rdat_valid_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic [AW-1:0]             wbm_adr_o,
   output logic [DW-1:0]             wbm_dat_o,
   output logic [DW/8-1:0]           wbm_sel_o,
   output logic                      wbm_we_o,
   output logic                      wbm_cyc_o,
   output logic                      wbm_stb_o,
   output logic [2:0]                wbm_cti_o,
   output logic [1:0]                wbm_bte_o,
   input  logic [DW-1:0]             wbm_dat_i,
   input  logic                      wbm_ack_i,
   input  logic                      wbm_err_i,
   input  logic                      wbm_rty_i
);
   localparam int LW = MAX_BURST_LOG2;
   localparam int CW = LW + 1;
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [AW-1:0] STEP = AW'(DW / 8);
   localparam logic [2:0] CTI_INC = 3'b010;
   localparam logic [2:0] CTI_END = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_WFILL, S_BURST, S_RGAP} state_t;

   state_t        r_state;
   logic [AW-1:0] r_adr;
   logic [LW-1:0] r_len;
   logic          r_we;
   logic [CW-1:0] r_beats;
   logic [RW-1:0] r_rty;
   logic          r_cyc;
   logic          r_stb;
   logic [2:0]    r_cti;
   logic          r_done;
   logic          r_err;
   logic          r_rdat_vld;
   logic [DW-1:0] r_rdat;
   logic          r_cmd_rdy;
   logic          r_wdat_rdy;

   logic          w_push;
   logic          w_pop;
   logic          w_fail;
   logic          w_flush;
   logic [DW-1:0] w_head;
   logic [CW-1:0] w_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_need;

   // Responses only count while stb is up; an exhausted retry budget turns rty into err.
   assign w_fail    = r_stb & (wbm_err_i | (wbm_rty_i & (r_rty == RW'(MAX_RETRY))));
   assign w_flush   = w_fail;
   assign w_pop     = r_stb & r_we & wbm_ack_i & ~wbm_rty_i & ~w_fail;
   assign w_push    = wdat_valid_i & r_wdat_rdy;
   assign w_cnt_nxt = w_cnt + CW'(w_push);
   assign w_need    = CW'(r_len) + CW'(1);

   wb_b3_burst_fifo #(.DW(DW), .LW(LW)) u_wfifo (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .i_push  (w_push),
      .i_dat   (wdat_i),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_head  (w_head),
      .o_cnt   (w_cnt)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state    <= S_IDLE;
         r_adr      <= '0;
         r_len      <= '0;
         r_we       <= 1'b0;
         r_beats    <= '0;
         r_rty      <= '0;
         r_cyc      <= 1'b0;
         r_stb      <= 1'b0;
         r_cti      <= 3'b000;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rdat_vld <= 1'b0;
         r_rdat     <= '0;
         r_cmd_rdy  <= 1'b0;
         r_wdat_rdy <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rdat_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cmd_rdy <= 1'b1;
               if (cmd_valid_i && r_cmd_rdy) begin
                  r_cmd_rdy <= 1'b0;
                  r_adr     <= cmd_adr_i;
                  r_len     <= cmd_len_i;
                  r_we      <= cmd_we_i;
                  r_beats   <= CW'(cmd_len_i) + CW'(1);
                  r_rty     <= '0;
                  if (cmd_we_i) begin
                     r_state    <= S_WFILL;
                     r_wdat_rdy <= 1'b1;
                  end else begin
                     r_state <= S_BURST;
                     r_cyc   <= 1'b1;
                     r_stb   <= 1'b1;
                     r_cti   <= (cmd_len_i == '0) ? CTI_END : CTI_INC;
                  end
               end
            end
            S_WFILL: begin
               // Ready is registered, so it looks one push ahead to never overfill.
               if (w_cnt_nxt == w_need) begin
                  r_wdat_rdy <= 1'b0;
                  r_state    <= S_BURST;
                  r_cyc      <= 1'b1;
                  r_stb      <= 1'b1;
                  r_cti      <= (r_len == '0) ? CTI_END : CTI_INC;
               end else begin
                  r_wdat_rdy <= 1'b1;
               end
            end
            S_BURST: begin
               if (w_fail) begin
                  r_cyc     <= 1'b0;
                  r_stb     <= 1'b0;
                  r_err     <= 1'b1;
                  r_cmd_rdy <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (r_stb && wbm_rty_i) begin
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_rty   <= r_rty + RW'(1);
                  r_state <= S_RGAP;
               end else if (r_stb && wbm_ack_i) begin
                  if (!r_we) begin
                     r_rdat_vld <= 1'b1;
                     r_rdat     <= wbm_dat_i;
                  end
                  if (r_beats > CW'(1)) begin
                     r_adr   <= r_adr + STEP;
                     r_beats <= r_beats - CW'(1);
                     r_cti   <= (r_beats > CW'(2)) ? CTI_INC : CTI_END;
                  end else begin
                     r_cyc     <= 1'b0;
                     r_stb     <= 1'b0;
                     r_done    <= 1'b1;
                     r_cmd_rdy <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_RGAP: begin
               r_state <= S_BURST;
               r_cyc   <= 1'b1;
               r_stb   <= 1'b1;
               r_cti   <= (r_beats > CW'(1)) ? CTI_INC : CTI_END;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready_o  = r_cmd_rdy;
   assign wdat_ready_o = r_wdat_rdy;
   assign rdat_o       = r_rdat;
   assign rdat_valid_o = r_rdat_vld;
   assign done_o       = r_done;
   assign err_o        = r_err;
   assign wbm_adr_o    = r_adr;
   assign wbm_dat_o    = (w_cnt == '0) ? '0 : w_head;
   assign wbm_sel_o    = '1;
   assign wbm_we_o     = r_we;
   assign wbm_cyc_o    = r_cyc;
   assign wbm_stb_o    = r_stb;
   assign wbm_cti_o    = r_cti;
   assign wbm_bte_o    = 2'b00;
endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed bench for wb_b3_burst_master with a behavioural registered-feedback RAM slave.
module tb_wb_b3_burst_master;
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_n_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_adr_i = '0;
   logic [3:0]  cmd_len_i = '0;
   logic [31:0] wdat_i = '0;
   logic        wdat_valid_i = 1'b0;
   logic        wdat_ready_o;
   logic [31:0] rdat_o;
   logic        rdat_valid_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;
   logic        wbm_rty_i = 1'b0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_b3_burst_master dut (
      .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
      .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
      .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .err_o(err_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave: acks every strobed cycle unless told to retry; also records what the master did.
   logic [31:0] mem [256];
   bit          rty_all = 1'b0;
   int          rty_at = -1;
   int          att = 0;
   int          idx = 0;
   int          cyc_n = 0;
   int          done_n = 0;
   int          err_n = 0;
   int          done_idx = 0;
   int          last_ack_idx = 0;
   logic [31:0] adr_q [$];
   logic [2:0]  cti_q [$];
   int          at_q [$];
   logic [31:0] rdat_q [$];

   always @(negedge wb_clk_i) begin
      idx++;
      wbm_ack_i = 1'b0;
      wbm_rty_i = 1'b0;
      wbm_err_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o) begin
         adr_q.push_back(wbm_adr_o);
         cti_q.push_back(wbm_cti_o);
         at_q.push_back(idx);
         cyc_n++;
         if (rty_all || att == rty_at) begin
            wbm_rty_i = 1'b1;
         end else begin
            wbm_ack_i = 1'b1;
            last_ack_idx = idx;
            if (wbm_we_o) mem[wbm_adr_o[9:2]] = wbm_dat_o;
         end
         wbm_dat_i = mem[wbm_adr_o[9:2]];
         att++;
      end
      if (rdat_valid_o) rdat_q.push_back(rdat_o);
      if (done_o) begin
         done_n++;
         done_idx = idx;
      end
      if (err_o) err_n++;
   end

   task automatic step();
      @(negedge wb_clk_i);
      #1;
   endtask

   task automatic clear();
      adr_q.delete(); cti_q.delete(); at_q.delete(); rdat_q.delete();
      att = 0; rty_at = -1; rty_all = 1'b0;
      cyc_n = 0; done_n = 0; err_n = 0;
   endtask

   task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] len);
      int k = 0;
      while (!cmd_ready_o && k < 50) begin
         step();
         k++;
      end
      if (k == 50) chk("cmd_ready_wait", cmd_ready_o, 1);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len;
      step();
      cmd_valid_i = 1'b0;
   endtask

   task automatic feed(input int n, input logic [31:0] base, input bit alt, output bit nocyc);
      int i = 0;
      int k = 0;
      bit pushed;
      nocyc = 1'b1;
      while (i < n && k < 200) begin
         if (alt && (k % 2 == 0)) wdat_valid_i = 1'b0;
         else begin
            wdat_valid_i = 1'b1;
            wdat_i = base + i;
         end
         if (wbm_cyc_o) nocyc = 1'b0;
         pushed = wdat_valid_i && wdat_ready_o;
         step();
         if (pushed) i++;
         k++;
      end
      wdat_valid_i = 1'b0;
      chk("feed_count", i, n);
   endtask

   task automatic wait_end(input int budget);
      int start = done_n + err_n;
      int k = 0;
      while (done_n + err_n == start && k < budget) begin
         step();
         k++;
      end
      if (done_n + err_n == start) chk("end_timeout", done_n + err_n, start + 1);
   endtask

   function automatic logic [31:0] qa(input int i);
      return (i < adr_q.size()) ? adr_q[i] : 32'hxxxxxxxx;
   endfunction
   function automatic logic [2:0] qc(input int i);
      return (i < cti_q.size()) ? cti_q[i] : 3'bxxx;
   endfunction
   function automatic logic [31:0] qr(input int i);
      return (i < rdat_q.size()) ? rdat_q[i] : 32'hxxxxxxxx;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit nocyc;
      logic [2:0] exp_cti [5];
      logic [31:0] exp_adr [5];
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;

      // Reset values
      #1;
      chk("rst_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, done_o, err_o,
                      rdat_valid_o, wdat_ready_o, cmd_ready_o}, 0);
      chk("rst_adr", wbm_adr_o, 0);
      chk("rst_dat", wbm_dat_o, 0);
      chk("rst_sel_bte", {wbm_sel_o, wbm_bte_o}, 6'b111100);
      step();
      wb_rst_n_i = 1'b1;
      step();
      chk("rdy_after_rst", cmd_ready_o, 1);

      // Read len=3 at 0x100
      clear();
      issue(1'b0, 32'h100, 4'd3);
      chk("t1_rd_lat", wbm_cyc_o, 1);
      chk("t1_rdy_busy", cmd_ready_o, 0);
      wait_end(40);
      chk("t1_rdy_with_done", cmd_ready_o, 1);
      chk("t1_cyc_n", cyc_n, 4);
      chk("t1_cti", {qc(0), qc(1), qc(2), qc(3)}, 12'b010_010_010_111);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_adr%0d", i), qa(i), 32'h100 + 4 * i);
         chk($sformatf("t1_rdat%0d", i), qr(i), 32'hA500_0040 + i);
      end
      chk("t1_rdat_n", rdat_q.size(), 4);
      chk("t1_done_n", done_n, 1);
      chk("t1_done_lat", done_idx, last_ack_idx + 1);

      // Write len=15 at 0x200, data offered every other cycle
      clear();
      issue(1'b1, 32'h200, 4'd15);
      feed(16, 32'hC0DE_0000, 1'b1, nocyc);
      chk("t2_nocyc_fill", nocyc, 1);
      chk("t2_burst_start", wbm_cyc_o, 1);
      wait_end(60);
      chk("t2_cyc_n", cyc_n, 16);
      chk("t2_gapfree", (at_q.size() == 16) ? at_q[15] - at_q[0] : -1, 15);
      chk("t2_cti_ends", {qc(0), qc(14), qc(15)}, 9'b010_010_111);
      chk("t2_done_n", done_n, 1);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t2_mem%0d", i), mem[8'h80 + i], 32'hC0DE_0000 + i);
      clear();
      issue(1'b0, 32'h200, 4'd15);
      wait_end(60);
      chk("t2_rb_n", rdat_q.size(), 16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t2_rb%0d", i), qr(i), 32'hC0DE_0000 + i);

      // Single-beat write
      clear();
      issue(1'b1, 32'h300, 4'd0);
      feed(1, 32'h5151_0000, 1'b0, nocyc);
      wait_end(20);
      chk("t3_beats", cti_q.size(), 1);
      chk("t3_cti", qc(0), 3'b111);
      chk("t3_done_n", done_n, 1);
      chk("t3_mem", mem[8'hC0], 32'h5151_0000);

      // Retry on the third strobed cycle of a 4-beat read
      clear();
      rty_at = 2;
      issue(1'b0, 32'h100, 4'd3);
      wait_end(40);
      exp_adr = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h10C};
      exp_cti = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
      chk("t4_cyc_n", cyc_n, 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4_adr%0d", i), qa(i), exp_adr[i]);
         chk($sformatf("t4_cti%0d", i), qc(i), exp_cti[i]);
      end
      chk("t4_gap", (at_q.size() == 5) ? at_q[3] - at_q[2] : -1, 2);
      chk("t4_rdat_n", rdat_q.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t4_rdat%0d", i), qr(i), 32'hA500_0040 + i);
      chk("t4_done_n", done_n, 1);

      // Sixteen consecutive retries abort; FIFO must come back empty
      clear();
      rty_all = 1'b1;
      issue(1'b1, 32'h380, 4'd1);
      feed(2, 32'hDEAD_0000, 1'b0, nocyc);
      wait_end(100);
      chk("t5_err_n", err_n, 1);
      chk("t5_done_n", done_n, 0);
      chk("t5_attempts", cyc_n, 16);
      chk("t5_rdy", cmd_ready_o, 1);
      clear();
      issue(1'b1, 32'h380, 4'd1);
      feed(2, 32'h7777_0000, 1'b0, nocyc);
      wait_end(20);
      chk("t5_post_done", done_n, 1);
      chk("t5_post_mem0", mem[8'hE0], 32'h7777_0000);
      chk("t5_post_mem1", mem[8'hE1], 32'h7777_0001);

      // Reset during a long read
      clear();
      issue(1'b0, 32'h000, 4'd15);
      step();
      step();
      #2 wb_rst_n_i = 1'b0;
      #1;
      chk("t6_async_drop", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      step();
      step();
      chk("t6_no_end", done_n + err_n, 0);
      wb_rst_n_i = 1'b1;
      step();
      clear();
      issue(1'b0, 32'h100, 4'd1);
      wait_end(20);
      chk("t6_done_n", done_n, 1);
      chk("t6_cti", {qc(0), qc(1)}, 6'b010_111);
      chk("t6_rdat0", qr(0), 32'hA500_0040);
      chk("t6_rdat1", qr(1), 32'hA500_0041);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
